// File: rtl/xadc_sample_framer.sv
// -----------------------------------------------------------------------------
// xadc_sample_framer
//
// Packs 32-bit XADC samples ({current[15:0], voltage[15:0]}) into byte frames
// for a downstream COBS encoder:
//
//   seq | SAMPLES_PER_FRAME x {b3, b2, b1, b0} | checksum
//
// The checksum is the two's complement of the mod-256 sum of all previous
// frame bytes, so that every frame sums to zero mod 256.
//
// Parameters
//   SAMPLES_PER_FRAME : samples per frame, 1..255
//   S_DATA_WIDTH      : input sample width, must be 32
//
// Ports
//   clk         : single clock for both streams
//   rst         : asynchronous, active-high reset
//   s_tdata     : input sample, [31:16] current channel, [15:0] voltage channel
//   s_tvalid    : input sample valid
//   s_tready    : block can accept a sample (IDLE or LOAD only)
//   m_tdata     : frame byte, registered
//   m_tvalid    : frame byte valid, registered
//   m_tready    : downstream accepts the byte
//   m_tlast     : high on the checksum byte only, registered
//   frame_count : number of completed frames, mod 256
// -----------------------------------------------------------------------------
module xadc_sample_framer #(
    parameter int SAMPLES_PER_FRAME = 4,
    parameter int S_DATA_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_WIDTH-1:0] s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [7:0]              m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [7:0]              frame_count
);

    localparam logic [7:0] SPF = 8'(SAMPLES_PER_FRAME);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEQ  = 3'd1,
        DATA = 3'd2,
        LOAD = 3'd3,
        CSUM = 3'd4
    } state_t;

    state_t                  state, nxt_state;
    logic [S_DATA_WIDTH-1:0] sample_q, nxt_sample;
    logic [1:0]              byte_idx, nxt_idx;
    logic [7:0]              sample_cnt, nxt_cnt;
    logic [7:0]              seq, nxt_seq;
    logic [7:0]              nxt_frame_count;
    logic [7:0]              sum, nxt_sum;
    logic [7:0]              nxt_tdata;
    logic                    nxt_tvalid, nxt_tlast;
    logic                    alive;
    logic                    in_hs, out_hs;

    // Byte idx of a sample, most-significant byte first.
    function automatic logic [7:0] byte_sel(input logic [31:0] s, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = s[31:24];
            2'd1:    byte_sel = s[23:16];
            2'd2:    byte_sel = s[15:8];
            default: byte_sel = s[7:0];
        endcase
    endfunction

    // s_tready stays low through reset and rises on the first edge after it.
    assign s_tready = alive && ((state == IDLE) || (state == LOAD));
    assign in_hs    = s_tvalid && s_tready;
    assign out_hs   = m_tvalid && m_tready;

    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned; a missed branch would otherwise infer a latch.
    always_comb begin
        nxt_state       = state;
        nxt_sample      = sample_q;
        nxt_idx         = byte_idx;
        nxt_cnt         = sample_cnt;
        nxt_seq         = seq;
        nxt_frame_count = frame_count;
        nxt_sum         = sum;
        nxt_tdata       = m_tdata;
        nxt_tvalid      = m_tvalid;
        nxt_tlast       = m_tlast;

        // The checksum accumulates a byte only once it has been accepted.
        if (out_hs) begin
            nxt_sum = sum + m_tdata;
        end

        case (state)
            IDLE: begin
                if (in_hs) begin
                    nxt_sample = s_tdata;
                    nxt_cnt    = 8'd1;  // counter restarts, this sample is the first
                    nxt_state  = SEQ;
                    nxt_tdata  = seq;
                    nxt_tvalid = 1'b1;
                    nxt_tlast  = 1'b0;
                end
            end
            SEQ: begin
                if (out_hs) begin
                    nxt_state = DATA;
                    nxt_idx   = 2'd0;
                    nxt_tdata = byte_sel(sample_q, 2'd0);
                end
            end
            DATA: begin
                if (out_hs) begin
                    if (byte_idx != 2'd3) begin
                        nxt_idx   = byte_idx + 2'd1;
                        nxt_tdata = byte_sel(sample_q, byte_idx + 2'd1);
                    end else if (sample_cnt < SPF) begin
                        nxt_state  = LOAD;
                        nxt_tvalid = 1'b0;
                        nxt_tdata  = 8'd0;
                    end else begin
                        // nxt_sum already includes the byte just accepted.
                        nxt_state = CSUM;
                        nxt_tdata = ~nxt_sum + 8'd1;
                        nxt_tlast = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_hs) begin
                    nxt_sample = s_tdata;
                    nxt_cnt    = sample_cnt + 8'd1;
                    nxt_state  = DATA;
                    nxt_idx    = 2'd0;
                    nxt_tdata  = byte_sel(s_tdata, 2'd0);
                    nxt_tvalid = 1'b1;
                end
            end
            CSUM: begin
                if (out_hs) begin
                    nxt_seq         = seq + 8'd1;
                    nxt_frame_count = frame_count + 8'd1;
                    nxt_sum         = 8'd0;
                    nxt_state       = IDLE;
                    nxt_tvalid      = 1'b0;
                    nxt_tlast       = 1'b0;
                    nxt_tdata       = 8'd0;
                end
            end
            default: begin
                nxt_state  = IDLE;
                nxt_tvalid = 1'b0;
                nxt_tlast  = 1'b0;
                nxt_tdata  = 8'd0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive       <= 1'b0;
            sample_q    <= '0;
            byte_idx    <= 2'd0;
            sample_cnt  <= 8'd0;
            seq         <= 8'd0;
            frame_count <= 8'd0;
            sum         <= 8'd0;
            m_tdata     <= 8'd0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
        end else begin
            alive       <= 1'b1;
            sample_q    <= nxt_sample;
            byte_idx    <= nxt_idx;
            sample_cnt  <= nxt_cnt;
            seq         <= nxt_seq;
            frame_count <= nxt_frame_count;
            sum         <= nxt_sum;
            m_tdata     <= nxt_tdata;
            m_tvalid    <= nxt_tvalid;
            m_tlast     <= nxt_tlast;
        end
    end

endmodule

// File: tb/tb_xadc_sample_framer.sv
// -----------------------------------------------------------------------------
// tb_xadc_sample_framer
//
// Instance dut2 (SAMPLES_PER_FRAME=2) runs a table of two-sample frames with
// hand-computed byte streams, then a mid-frame reset. Instance dut1
// (SAMPLES_PER_FRAME=1) streams 257 all-zero frames to exercise seq wrap.
// -----------------------------------------------------------------------------
module tb_xadc_sample_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- N = 2 instance ----
    logic        rst2 = 1'b1;
    logic [31:0] s_tdata2 = '0;
    logic        s_tvalid2 = 1'b0;
    logic        s_tready2;
    logic [7:0]  m_tdata2;
    logic        m_tvalid2;
    logic        m_tready2 = 1'b1;
    logic        m_tlast2;
    logic [7:0]  frame_count2;

    xadc_sample_framer #(.SAMPLES_PER_FRAME(2), .S_DATA_WIDTH(32)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .s_tdata    (s_tdata2),
        .s_tvalid   (s_tvalid2),
        .s_tready   (s_tready2),
        .m_tdata    (m_tdata2),
        .m_tvalid   (m_tvalid2),
        .m_tready   (m_tready2),
        .m_tlast    (m_tlast2),
        .frame_count(frame_count2)
    );

    // ---- N = 1 instance ----
    logic        rst1 = 1'b1;
    logic [31:0] s_tdata1 = '0;
    logic        s_tvalid1 = 1'b0;
    logic        s_tready1;
    logic [7:0]  m_tdata1;
    logic        m_tvalid1;
    logic        m_tready1 = 1'b1;
    logic        m_tlast1;
    logic [7:0]  frame_count1;

    xadc_sample_framer #(.SAMPLES_PER_FRAME(1), .S_DATA_WIDTH(32)) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .s_tdata    (s_tdata1),
        .s_tvalid   (s_tvalid1),
        .s_tready   (s_tready1),
        .m_tdata    (m_tdata1),
        .m_tvalid   (m_tvalid1),
        .m_tready   (m_tready1),
        .m_tlast    (m_tlast1),
        .frame_count(frame_count1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- downstream ready driver for dut2 ----
    bit rand_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready2 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---- dut2 output monitor: byte capture + stall stability ----
    logic [7:0] bq[$];
    logic       lq[$];
    bit         stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        if (rst2) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", {23'd0, m_tvalid2, m_tlast2, m_tdata2},
                      {23'd0, 1'b1, prev_last, prev_data});
            end
            stall_prev = m_tvalid2 && !m_tready2;
            prev_data  = m_tdata2;
            prev_last  = m_tlast2;
            if (m_tvalid2 && m_tready2) begin
                bq.push_back(m_tdata2);
                lq.push_back(m_tlast2);
            end
        end
    end

    // Offer one sample to dut2 after `gap` idle cycles; optionally confirm the
    // block is parked in LOAD near the end of the gap.
    task automatic push2(input logic [31:0] d, input int gap, input bit chk_load);
        bit hs = 1'b0;
        s_tvalid2 = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (chk_load && i >= gap - 3) begin
                check("load_m_tvalid", {31'd0, m_tvalid2}, 32'd0);
                check("load_s_tready", {31'd0, s_tready2}, 32'd1);
            end
            @(posedge clk);
            #1;
        end
        s_tdata2  = d;
        s_tvalid2 = 1'b1;
        for (int k = 0; k < 500 && !hs; k++) begin
            @(negedge clk);
            hs = s_tready2;
            @(posedge clk);
            #1;
        end
        if (!hs) check("input_handshake_timeout", 32'd0, 32'd1);
        s_tvalid2 = 1'b0;
    endtask

    typedef struct {
        logic [31:0] s0;
        logic [31:0] s1;
        int          gap;
        bit          rnd;
        logic [79:0] exp;   // 10 frame bytes, first byte in [79:72]
        logic [7:0]  fc;    // frame_count after the frame
    } vec_t;

    vec_t vecs[5];

    task automatic wait_bytes(input int n);
        for (int k = 0; k < 400 && bq.size() < n; k++) @(posedge clk);
        #1;
        if (bq.size() < n) check("frame_timeout", bq.size(), n);
    endtask

    task automatic check_frame(input vec_t v, input int id);
        logic [79:0] e;
        e = v.exp;
        check($sformatf("v%0d_len", id), bq.size(), 32'd10);
        for (int i = 0; i < 10 && i < bq.size(); i++) begin
            check($sformatf("v%0d_byte%0d", id, i), {24'd0, bq[i]}, {24'd0, e[79-8*i -: 8]});
            check($sformatf("v%0d_last%0d", id, i), {31'd0, lq[i]}, {31'd0, (i == 9)});
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d_frame_count", id), {24'd0, frame_count2}, {24'd0, v.fc});
        bq.delete();
        lq.delete();
    endtask

    task automatic run_frame(input vec_t v, input int id);
        rand_ready = v.rnd;
        push2(v.s0, 0, 1'b0);
        push2(v.s1, v.gap, (v.gap >= 8));
        wait_bytes(10);
        rand_ready = 1'b0;
        check_frame(v, id);
    endtask

    initial begin
        vecs[0] = '{32'h01020304, 32'h0A0B0C0D, 0,  1'b0, 80'h00_01020304_0A0B0C0D_C8, 8'd1};
        vecs[1] = '{32'h01020304, 32'h0A0B0C0D, 0,  1'b0, 80'h01_01020304_0A0B0C0D_C7, 8'd2};
        vecs[2] = '{32'h01020304, 32'h0A0B0C0D, 0,  1'b1, 80'h02_01020304_0A0B0C0D_C6, 8'd3};
        vecs[3] = '{32'h01020304, 32'h0A0B0C0D, 10, 1'b0, 80'h03_01020304_0A0B0C0D_C5, 8'd4};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 0,  1'b1, 80'h04_FFFFFFFF_00000001_FF, 8'd5};

        // ---- reset state ----
        #12;
        check("rst_s_tready", {31'd0, s_tready2}, 32'd0);
        check("rst_m_tvalid", {31'd0, m_tvalid2}, 32'd0);
        check("rst_m_tlast",  {31'd0, m_tlast2}, 32'd0);
        check("rst_m_tdata",  {24'd0, m_tdata2}, 32'd0);
        check("rst_frame_count", {24'd0, frame_count2}, 32'd0);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        #2;
        check("s_tready_before_edge", {31'd0, s_tready2}, 32'd0);
        @(posedge clk);
        #1;
        check("s_tready_after_edge", {31'd0, s_tready2}, 32'd1);

        // ---- table-driven frames ----
        foreach (vecs[i]) run_frame(vecs[i], i);

        // ---- reset after the 3rd byte of a frame ----
        push2(32'h01020304, 0, 1'b0);
        for (int k = 0; k < 100 && bq.size() < 3; k++) @(negedge clk);
        check("mid_rst_bytes_seen", bq.size(), 32'd3);
        @(posedge clk);
        #2;
        rst2 = 1'b1;
        #1;
        check("mid_rst_m_tvalid", {31'd0, m_tvalid2}, 32'd0);
        check("mid_rst_m_tdata",  {24'd0, m_tdata2}, 32'd0);
        check("mid_rst_m_tlast",  {31'd0, m_tlast2}, 32'd0);
        check("mid_rst_s_tready", {31'd0, s_tready2}, 32'd0);
        check("mid_rst_frame_count", {24'd0, frame_count2}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b0;
        bq.delete();
        lq.delete();
        repeat (4) @(negedge clk);
        check("post_rst_idle_quiet", bq.size(), 32'd0);
        @(posedge clk);
        #1;
        run_frame(vecs[0], 5);

        // ---- N = 1: 257 zero frames, seq wrap, no LOAD detour ----
        begin
            int fr = 0;
            int pos = 0;
            int last_cyc = 0;
            @(posedge clk);
            #1;
            rst1 = 1'b0;
            s_tdata1  = 32'd0;
            s_tvalid1 = 1'b1;
            m_tready1 = 1'b1;
            for (int cyc = 0; cyc < 4000 && fr < 257; cyc++) begin
                @(negedge clk);
                if (m_tvalid1 && m_tready1) begin
                    if (pos == 0) begin
                        check($sformatf("n1_seq_f%0d", fr), {24'd0, m_tdata1}, {24'd0, 8'(fr)});
                        check($sformatf("n1_last_f%0d_p0", fr), {31'd0, m_tlast1}, 32'd0);
                        pos++;
                    end else if (pos < 5) begin
                        check($sformatf("n1_data_f%0d_p%0d", fr, pos), {24'd0, m_tdata1}, 32'd0);
                        check($sformatf("n1_last_f%0d_p%0d", fr, pos), {31'd0, m_tlast1}, 32'd0);
                        pos++;
                    end else begin
                        check($sformatf("n1_csum_f%0d", fr), {24'd0, m_tdata1},
                              {24'd0, 8'(9'h100 - {1'b0, 8'(fr)})});
                        check($sformatf("n1_tlast_f%0d", fr), {31'd0, m_tlast1}, 32'd1);
                        if (fr > 0) check($sformatf("n1_period_f%0d", fr), cyc - last_cyc, 32'd7);
                        last_cyc = cyc;
                        fr++;
                        pos = 0;
                    end
                end
            end
            check("n1_frames_done", fr, 32'd257);
            @(posedge clk);
            #1;
            check("n1_frame_count_wrap", {24'd0, frame_count1}, 32'd1);
            s_tvalid1 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xadc_sample_framer.md
XADC_SAMPLE_FRAMER -- requirements
Module: xadc_sample_framer

Interface
REQ-001 The block SHALL have parameter SAMPLES_PER_FRAME, default 4, meaning the number of 32-bit samples per frame (legal range 1..255).
REQ-002 The block SHALL have parameter S_DATA_WIDTH, default 32, meaning the input sample width; only 32 is supported.
REQ-003 The block SHALL have port clk, input, 1, the single clock shared by both streams.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port s_tdata, input, 32: [31:16] is the current-sensor channel sample and [15:0] is the voltage channel sample, from the XADC DRP stream adapter.
REQ-006 The block SHALL have ports s_tvalid (input, 1) and s_tready (output, 1), the AXIS sink handshake.
REQ-007 The block SHALL have port m_tdata, output, 8, the frame byte towards the COBS encoder.
REQ-008 The block SHALL have ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1), the AXIS source handshake; m_tlast marks the final frame byte.
REQ-009 The block SHALL have port frame_count, output, 8, the number of completed frames modulo 256.

Function
REQ-010 Frame format SHALL be:
- 1 sequence byte;
- SAMPLES_PER_FRAME x 4 sample bytes;
- 1 checksum byte;
- total length 4*SAMPLES_PER_FRAME+2 bytes.
REQ-011 Sample bytes SHALL be emitted most-significant first: [31:24], [23:16], [15:8], [7:0].
REQ-012 The checksum SHALL be the 8-bit two's complement of the mod-256 sum of the sequence and sample bytes, so the sum of all frame bytes equals 0 mod 256.
REQ-013 The FSM SHALL have states IDLE, SEQ, DATA, LOAD, CSUM.
REQ-014 In IDLE, s_tready SHALL be 1; on an s_tvalid&&s_tready handshake the block SHALL latch the sample, clear the sample counter, and go to SEQ.
REQ-015 In SEQ, the block SHALL drive m_tdata=seq and m_tvalid=1; on handshake it SHALL go to DATA with byte index 0.
REQ-016 In DATA, the block SHALL emit the latched sample bytes by index:
- on each handshake, index increments;
- after index 3 is accepted, go to LOAD if fewer than SAMPLES_PER_FRAME samples have been sent, else go to CSUM.
REQ-017 In LOAD, s_tready SHALL be 1 and m_tvalid SHALL be 0; on an input handshake the block SHALL latch the sample and go to DATA with index 0.
REQ-018 In CSUM, the block SHALL drive m_tdata=checksum, m_tvalid=1 and m_tlast=1; on handshake it SHALL increment seq and frame_count (255 wraps to 0), clear the running sum, and go to IDLE.
REQ-019 s_tready SHALL be 0 in SEQ, DATA and CSUM; upstream stalls via backpressure and no sample is ever dropped.
REQ-020 m_tvalid, m_tdata and m_tlast SHALL be registered; while m_tvalid=1 and m_tready=0, these outputs SHALL hold stable.
REQ-021 m_tlast SHALL be 0 on every byte except the checksum byte.
REQ-022 Latency SHALL be one cycle: the sequence byte is valid on the cycle after the IDLE accept, and each subsequent byte is valid on the cycle after the previous handshake (LOAD waits for s_tvalid).
REQ-023 With m_tready held at 1 and s_tvalid held at 1, a frame SHALL take 5*SAMPLES_PER_FRAME+2 cycles.
REQ-024 The running checksum SHALL accumulate each byte on its output handshake, not when it is presented.
REQ-025 With SAMPLES_PER_FRAME=1, the block SHALL go DATA -> CSUM directly and never enter LOAD.

Reset
REQ-026 Asserting rst SHALL asynchronously force:
- state=IDLE;
- s_tready=0 while rst is high;
- m_tvalid=0, m_tlast=0, m_tdata=0;
- seq=0, frame_count=0, running sum=0, counters=0.
REQ-027 Reset asserted mid-frame SHALL abandon the partial frame with no further bytes emitted; the first frame after reset SHALL carry seq 0x00.
REQ-028 After rst deasserts, s_tready SHALL rise on the next clk edge.

Verification
REQ-029 With N=2, m_tready=1, samples 0x01020304 then 0x0A0B0C0D -> m_tdata shall be 00 01 02 03 04 0A 0B 0C 0D C8, with m_tlast only on C8.
REQ-030 Sending the same two samples again -> the frame shall start 01 and end with checksum C7; frame_count shall equal 2.
REQ-031 With m_tready randomly deasserted at 50% -> the byte sequence shall be identical to REQ-029, and outputs shall stay stable during stalls.
REQ-032 With s_tvalid gapped by 10 cycles between samples -> the block shall wait in LOAD with m_tvalid=0, and the frame content shall be unchanged.
REQ-033 Asserting rst after the 3rd byte of a frame -> outputs shall be 0 immediately; the next frame shall start with 00 and have a correct checksum.
REQ-034 Running 257 frames of all-zero samples with N=1 -> seq shall wrap FF->00, and each checksum shall equal (0x100-seq) mod 256.
